// File: rtl/btn_debounce.sv
// Four-channel push-button conditioner: synchronizer, debounce and
// auto-repeat per button. Channels are identical and fully independent.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 650000,
  parameter int unsigned REPEAT_DELAY    = 19500000,
  parameter int unsigned REPEAT_PERIOD   = 6500000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [3:0] btn_in,
  output logic [3:0] btn_lvl,
  output logic [3:0] btn_press,
  output logic [3:0] btn_rep
);

  // Terminal counts; counters clear on reaching them so they never wrap.
  localparam logic [31:0] DB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] RD_LAST  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RP_LAST  = 32'(REPEAT_PERIOD - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      logic        sync1_reg;
      logic        sync2_reg;
      logic        lvl_reg;
      logic        press_reg;
      logic        rep_reg;
      logic [31:0] db_cnt_reg;
      logic [31:0] rep_cnt_reg;
      logic [1:0]  state_reg;
      logic        accept;
      logic        rise;
      logic        fall;

      // Level change is accepted once the mismatch has lasted the full window.
      assign accept = (sync2_reg != lvl_reg) && (db_cnt_reg == DB_LAST);
      assign rise   = accept &&  sync2_reg;
      assign fall   = accept && !sync2_reg;

      // Two-flop synchronizer for the asynchronous button input.
      always_ff @(posedge pclk) begin
        if (rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
        end else begin
          sync1_reg <= btn_in[gi];
          sync2_reg <= sync1_reg;
        end
      end

      // Debounce: count consecutive mismatches, flip level at terminal count.
      always_ff @(posedge pclk) begin
        if (rst) begin
          lvl_reg    <= 1'b0;
          press_reg  <= 1'b0;
          db_cnt_reg <= 32'd0;
        end else begin
          press_reg <= rise;
          if (sync2_reg == lvl_reg) begin
            db_cnt_reg <= 32'd0;
          end else if (accept) begin
            lvl_reg    <= sync2_reg;
            db_cnt_reg <= 32'd0;
          end else begin
            db_cnt_reg <= db_cnt_reg + 32'd1;
          end
        end
      end

      // Auto-repeat FSM: pulse on press, after the delay, then periodically.
      // Release wins over any repeat scheduled on the same edge.
      always_ff @(posedge pclk) begin
        if (rst) begin
          state_reg   <= ST_IDLE;
          rep_cnt_reg <= 32'd0;
          rep_reg     <= 1'b0;
        end else if (fall) begin
          state_reg   <= ST_IDLE;
          rep_cnt_reg <= 32'd0;
          rep_reg     <= 1'b0;
        end else begin
          case (state_reg)
            ST_IDLE: begin
              rep_cnt_reg <= 32'd0;
              if (rise) begin
                state_reg <= ST_DELAY;
                rep_reg   <= 1'b1;
              end else begin
                rep_reg   <= 1'b0;
              end
            end
            ST_DELAY: begin
              if (rep_cnt_reg == RD_LAST) begin
                state_reg   <= ST_REPEAT;
                rep_cnt_reg <= 32'd0;
                rep_reg     <= 1'b1;
              end else begin
                rep_cnt_reg <= rep_cnt_reg + 32'd1;
                rep_reg     <= 1'b0;
              end
            end
            ST_REPEAT: begin
              if (rep_cnt_reg == RP_LAST) begin
                rep_cnt_reg <= 32'd0;
                rep_reg     <= 1'b1;
              end else begin
                rep_cnt_reg <= rep_cnt_reg + 32'd1;
                rep_reg     <= 1'b0;
              end
            end
            default: begin
              state_reg   <= ST_IDLE;
              rep_cnt_reg <= 32'd0;
              rep_reg     <= 1'b0;
            end
          endcase
        end
      end

      assign btn_lvl[gi]   = lvl_reg;
      assign btn_press[gi] = press_reg;
      assign btn_rep[gi]   = rep_reg;
    end
  endgenerate

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with short timing parameters: per-cycle comparison
// against a timing model plus literal checks at hand-computed edges.
module tb_btn_debounce;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       pclk;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_lvl;
  logic [3:0] btn_press;
  logic [3:0] btn_rep;

  btn_debounce #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .btn_in(btn_in),
    .btn_lvl(btn_lvl),
    .btn_press(btn_press),
    .btn_rep(btn_rep)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;   // number of rising edges seen so far

  // Model state
  logic [3:0] m_s1 = '0, m_s2 = '0;
  logic [3:0] exp_lvl = '0, exp_press = '0, exp_rep = '0;
  int         run[4];
  int         t0[4];

  // Behavioural model: level accepted after D consecutive mismatching
  // synchronized samples; repeat pulses at age 0, RD, RD+RP, RD+2RP, ...
  initial begin
    for (int c = 0; c < 4; c++) begin
      run[c] = 0;
      t0[c]  = 0;
    end
    forever begin
      @(posedge pclk);
      cyc++;
      if (rst) begin
        m_s1 = '0; m_s2 = '0;
        exp_lvl = '0; exp_press = '0; exp_rep = '0;
        for (int c = 0; c < 4; c++) run[c] = 0;
      end else begin
        logic [3:0] s;
        logic [3:0] prev;
        s    = m_s2;
        m_s2 = m_s1;
        m_s1 = btn_in;
        prev = exp_lvl;
        for (int c = 0; c < 4; c++) begin
          if (s[c] != exp_lvl[c]) begin
            run[c]++;
            if (run[c] == D) begin
              exp_lvl[c] = s[c];
              run[c] = 0;
            end
          end else begin
            run[c] = 0;
          end
          exp_press[c] = !prev[c] && exp_lvl[c];
          if (exp_press[c]) t0[c] = cyc;
          if (!exp_lvl[c]) begin
            exp_rep[c] = 1'b0;
          end else begin
            int age;
            age = cyc - t0[c];
            exp_rep[c] = (age == 0) || (age >= RD && ((age - RD) % RP) == 0);
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge pclk);
      if (cyc > 0) begin
        total++;
        if (btn_lvl !== exp_lvl || btn_press !== exp_press || btn_rep !== exp_rep) begin
          bad++;
          $display("FAIL model edge=%0d lvl/press/rep got=%b/%b/%b want=%b/%b/%b",
                   cyc, btn_lvl, btn_press, btn_rep, exp_lvl, exp_press, exp_rep);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s edge=%0d got=%b want=%b", name, cyc, got, want);
    end else begin
      $display("check %s edge=%0d value=%b ok", name, cyc, got);
    end
  endtask

  task automatic wait_until(input int e);
    int guard;
    guard = 0;
    while (cyc < e && guard < 2000) begin
      @(negedge pclk);
      guard++;
    end
    if (cyc < e) begin
      bad++;
      total++;
      $display("FAIL wait_timeout edge=%0d want=%0d", cyc, e);
    end
  endtask

  int k, m, l, k2, k3, c0, r;

  initial begin
    rst = 1'b1;
    btn_in = 4'b0000;
    repeat (3) @(negedge pclk);
    chk("reset_lvl", btn_lvl, 4'b0000);
    chk("reset_press", btn_press, 4'b0000);
    chk("reset_rep", btn_rep, 4'b0000);
    rst = 1'b0;
    repeat (4) @(negedge pclk);

    // Clean hold on bit 0
    btn_in = 4'b0001; k = cyc + 1;
    wait_until(k + 4);  chk("hold_lvl_k4", btn_lvl, 4'b0000);
    wait_until(k + 5);  chk("hold_lvl_k5", btn_lvl, 4'b0001);
                        chk("hold_press_k5", btn_press, 4'b0001);
                        chk("hold_rep_k5", btn_rep, 4'b0001);
    wait_until(k + 6);  chk("hold_press_k6", btn_press, 4'b0000);
                        chk("hold_rep_k6", btn_rep, 4'b0000);
    wait_until(k + 15); chk("hold_rep_k15", btn_rep, 4'b0001);
    wait_until(k + 16); chk("hold_rep_k16", btn_rep, 4'b0000);
    wait_until(k + 18); chk("hold_rep_k18", btn_rep, 4'b0001);
    wait_until(k + 21); chk("hold_rep_k21", btn_rep, 4'b0001);

    // Release timed so the fall lands on the repeat due at k+33
    wait_until(k + 27);
    btn_in = 4'b0000; m = cyc + 1;
    wait_until(m + 4);  chk("rel_lvl_m4", btn_lvl, 4'b0001);
    wait_until(m + 5);  chk("rel_lvl_m5", btn_lvl, 4'b0000);
                        chk("rel_press_m5", btn_press, 4'b0000);
                        chk("rel_rep_m5", btn_rep, 4'b0000);
    wait_until(m + 8);  chk("rel_rep_m8", btn_rep, 4'b0000);
    repeat (6) @(negedge pclk);

    // Bounce on bit 2: toggles every 3 cycles for 30 cycles
    for (int i = 0; i < 10; i++) begin
      btn_in = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      repeat (3) @(negedge pclk);
    end
    chk("bounce_lvl", btn_lvl, 4'b0000);
    btn_in = 4'b0100; l = cyc + 1;
    wait_until(l + 4);  chk("bounce_lvl_l4", btn_lvl, 4'b0000);
    wait_until(l + 5);  chk("bounce_lvl_l5", btn_lvl, 4'b0100);
                        chk("bounce_press_l5", btn_press, 4'b0100);
    btn_in = 4'b0000;
    repeat (12) @(negedge pclk);

    // Simultaneous bits 0 and 2
    btn_in = 4'b0101; k2 = cyc + 1;
    wait_until(k2 + 4); chk("simul_lvl_k4", btn_lvl, 4'b0000);
    wait_until(k2 + 5); chk("simul_lvl_k5", btn_lvl, 4'b0101);
                        chk("simul_press_k5", btn_press, 4'b0101);
                        chk("simul_rep_k5", btn_rep, 4'b0101);
    wait_until(k2 + 6); chk("simul_press_k6", btn_press, 4'b0000);
    btn_in = 4'b0000;
    repeat (12) @(negedge pclk);

    // Reset while bit 1 is in the repeat phase, button held throughout
    btn_in = 4'b0010; k3 = cyc + 1;
    wait_until(k3 + 5 + RD + RP + 1);
    chk("mid_lvl", btn_lvl, 4'b0010);
    rst = 1'b1; c0 = cyc;
    wait_until(c0 + 1);
    chk("rst_lvl", btn_lvl, 4'b0000);
    chk("rst_press", btn_press, 4'b0000);
    chk("rst_rep", btn_rep, 4'b0000);
    rst = 1'b0; r = c0 + 2;
    wait_until(r + 4);  chk("post_press_r4", btn_press, 4'b0000);
    wait_until(r + 5);  chk("post_press_r5", btn_press, 4'b0010);
                        chk("post_rep_r5", btn_rep, 4'b0010);
    wait_until(r + 15); chk("post_rep_r15", btn_rep, 4'b0010);
    repeat (3) @(negedge pclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
